// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared defaults and state encoding for fb_write_arbiter
//
// Purpose: framebuffer geometry defaults, clear colour and the arbiter FSM
//          state encoding, imported by fb_write_arbiter and rr_arbiter.
// Ports:   none (package).
package fb_arb_pkg;

  localparam int          DEF_ADDR_W      = 15;
  localparam int          DEF_DATA_W      = 24;
  localparam int          DEF_FB_DEPTH    = 19200;  // 160x120
  localparam logic [23:0] DEF_CLEAR_COLOR = 24'h000000;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
//
// Purpose: picks the lowest-index valid requester at or above the pointer,
//          wrapping around; purely combinational.
// Ports:
//   valid  in   NUM_REQ  request vector
//   ptr    in   PTR_W    round-robin start index
//   grant  out  NUM_REQ  one-hot grant, zero when nothing is valid
//   idx    out  PTR_W    index of the granted requester (0 when none)
module rr_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);

  int               j;
  logic [PTR_W-1:0] jj;

  // Walk offsets from farthest to nearest so the closest valid requester
  // (in wrapped order from ptr) is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = PTR_W'(j);
      if (valid[jj]) begin
        grant     = '0;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin framebuffer write arbiter with clear sweep
//
// Purpose: shares one framebuffer write port among NUM_REQ pixel producers
//          using valid/ready handshakes and round-robin priority; on request
//          performs a full-screen clear sweep starting at a frame_done edge.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   frame_done    end-of-frame pulse
//   clear_req     clear-screen request pulse (taken at next frame_done)
//   req_valid     per-requester write request
//   req_ready     per-requester accept (one-hot or zero)
//   req_addr      packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data      packed pixel data, requester i at [i*DATA_W +: DATA_W]
//   fb_addr/fb_data/fb_we  registered framebuffer write port
//   clearing      high while the clear sweep FSM state is active
//   oob_err       sticky out-of-range accepted address flag
//   stat_writes   (FB_ARB_STATS_EN only) per-requester 16-bit write counts
//                 snapshotted at frame_done
// Build option: define FB_ARB_STATS_EN to add the stat_writes counters.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int                 NUM_REQ     = 3,
  parameter int                 ADDR_W      = DEF_ADDR_W,
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 FB_DEPTH    = DEF_FB_DEPTH,
  parameter logic [DATA_W-1:0]  CLEAR_COLOR = DATA_W'(DEF_CLEAR_COLOR)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_done,
  input  logic                        clear_req,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [ADDR_W-1:0]           fb_addr,
  output logic [DATA_W-1:0]           fb_data,
  output logic                        fb_we,
  output logic                        clearing,
  output logic                        oob_err
`ifdef FB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       stat_writes
`endif
);

  localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);

  arb_state_t          state, state_next;
  logic [PTR_W-1:0]    ptr, ptr_next;
  logic                clear_pending, pend_next;
  logic [ADDR_W-1:0]   cnt, cnt_next;
  logic                we_next, oob_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [DATA_W-1:0]   data_next;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    gidx;
  logic                xfer;
  logic                start_clear;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  // Ready is forced low during reset so no producer sees a phantom accept.
  assign req_ready   = (state == ARB && !rst) ? grant : '0;
  assign xfer        = |(req_valid & req_ready);
  assign start_clear = frame_done & (clear_pending | clear_req);
  assign clearing    = (state == CLEAR);
  assign sel_addr    = req_addr[gidx*ADDR_W +: ADDR_W];
  assign sel_data    = req_data[gidx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARB;
      ptr           <= '0;
      clear_pending <= 1'b0;
      cnt           <= '0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_data       <= '0;
      oob_err       <= 1'b0;
    end else begin
      state         <= state_next;
      ptr           <= ptr_next;
      clear_pending <= pend_next;
      cnt           <= cnt_next;
      fb_we         <= we_next;
      fb_addr       <= addr_next;
      fb_data       <= data_next;
      oob_err       <= oob_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    pend_next  = clear_pending;
    cnt_next   = cnt;
    we_next    = 1'b0;
    addr_next  = fb_addr;
    data_next  = fb_data;
    oob_next   = oob_err;
    case (state)
      ARB: begin
        if (xfer) begin
          ptr_next = (gidx == LAST_IDX) ? '0 : gidx + PTR_W'(1);
          // Out-of-range writes are accepted but dropped, and flagged.
          if (sel_addr > LAST_ADDR) begin
            oob_next = 1'b1;
          end else begin
            we_next   = 1'b1;
            addr_next = sel_addr;
            data_next = sel_data;
          end
        end
        if (start_clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
          pend_next  = 1'b0;
        end else if (clear_req) begin
          pend_next = 1'b1;
        end
      end
      CLEAR: begin
        we_next   = 1'b1;
        addr_next = cnt;
        data_next = CLEAR_COLOR;
        // A request during the sweep is held for the next frame boundary.
        if (clear_req) pend_next = 1'b1;
        if (cnt == LAST_ADDR) begin
          state_next = ARB;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ADDR_W'(1);
        end
      end
      default: state_next = ARB;
    endcase
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] live_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_writes <= '0;
      for (int i = 0; i < NUM_REQ; i++) live_cnt[i] <= '0;
    end else if (frame_done) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_writes[i*16 +: 16] <= live_cnt[i];
        live_cnt[i]             <= '0;
      end
    end else if (xfer && live_cnt[gidx] != 16'hFFFF) begin
      live_cnt[gidx] <= live_cnt[gidx] + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 15;
  localparam int DW = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_done = 1'b0;
  logic            clear_req = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [AW-1:0]   fb_addr;
  logic [DW-1:0]   fb_data;
  logic            fb_we;
  logic            clearing;
  logic            oob_err;

  int checks = 0;
  int failures = 0;
  int sweep_errs = 0;

  fb_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .clear_req  (clear_req),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .clearing   (clearing),
    .oob_err    (oob_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Expect one clear write per cycle, addresses first..last, ready held low.
  task automatic run_sweep(input int first, input int last, input int clr_at, input int fd_at);
    for (int n = first; n <= last; n++) begin
      clear_req  = (n == clr_at);
      frame_done = (n == fd_at);
      #1;
      if (req_ready !== 3'b000 || clearing !== 1'b1) sweep_errs++;
      step;
      if (fb_we !== 1'b1 || fb_addr !== AW'(n) || fb_data !== 24'h000000) sweep_errs++;
    end
    clear_req  = 1'b0;
    frame_done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_req(i, AW'(10 + i), DW'(24'hA00000 + i));
    req_valid = 3'b111;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_we", 32'(fb_we), 32'h0);
    check("rst_addr", 32'(fb_addr), 32'h0);
    check("rst_data", 32'(fb_data), 32'h0);
    check("rst_clearing", 32'(clearing), 32'h0);
    check("rst_oob", 32'(oob_err), 32'h0);
    step;
    step;
    rst = 1'b0;

    // All three valid: grants rotate 0,1,2,... with a write every cycle.
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      step;
      check("rr_we", 32'(fb_we), 32'h1);
      check("rr_addr", 32'(fb_addr), 32'(10 + k % 3));
      check("rr_data", 32'(fb_data), 32'(24'hA00000 + k % 3));
    end
    req_valid = 3'b000;
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    step;
    check("idle_we", 32'(fb_we), 32'h0);
    check("idle_addr_hold", 32'(fb_addr), 32'd12);
    check("idle_data_hold", 32'(fb_data), 32'hA00002);

    // Requester 1 alone: one-cycle latency to the write port.
    set_req(1, AW'(100), 24'hFF0000);
    req_valid = 3'b010;
    #1;
    check("r1_ready", 32'(req_ready), 32'h2);
    step;
    check("r1_we", 32'(fb_we), 32'h1);
    check("r1_addr", 32'(fb_addr), 32'd100);
    check("r1_data", 32'(fb_data), 32'hFF0000);
    req_valid = 3'b000;
    step;
    check("r1_we_drop", 32'(fb_we), 32'h0);

    // Requester 0 out of range, then at the last valid address.
    set_req(0, AW'(19200), 24'h000123);
    req_valid = 3'b001;
    #1;
    check("oob_ready", 32'(req_ready), 32'h1);
    step;
    check("oob_we", 32'(fb_we), 32'h0);
    check("oob_flag", 32'(oob_err), 32'h1);
    check("oob_addr_hold", 32'(fb_addr), 32'd100);
    set_req(0, AW'(19199), 24'h55AA55);
    #1;
    check("edge_ready", 32'(req_ready), 32'h1);
    step;
    check("edge_we", 32'(fb_we), 32'h1);
    check("edge_addr", 32'(fb_addr), 32'd19199);
    check("oob_sticky", 32'(oob_err), 32'h1);
    req_valid = 3'b000;

    // clear_req, then frame_done 10 cycles later with a concurrent transfer.
    clear_req = 1'b1;
    step;
    clear_req = 1'b0;
    check("pend_clearing", 32'(clearing), 32'h0);
    repeat (9) step;
    check("pend_we", 32'(fb_we), 32'h0);
    set_req(2, AW'(500), 24'h123456);
    req_valid  = 3'b100;
    frame_done = 1'b1;
    #1;
    check("start_ready", 32'(req_ready), 32'h4);
    step;
    frame_done = 1'b0;
    check("start_clearing", 32'(clearing), 32'h1);
    check("start_xfer_addr", 32'(fb_addr), 32'd500);
    check("start_xfer_we", 32'(fb_we), 32'h1);
    sweep_errs = 0;
    run_sweep(0, 19199, -1, -1);
    check("sweep1_errs", 32'(sweep_errs), 32'h0);
    check("sweep1_done", 32'(clearing), 32'h0);
    #1;
    check("resume_ready", 32'(req_ready), 32'h4);
    step;
    check("resume_addr", 32'(fb_addr), 32'd500);
    check("resume_we", 32'(fb_we), 32'h1);

    // frame_done with clear_req in the same cycle; frame_done alone mid-sweep
    // is ignored; clear_req mid-sweep triggers another sweep.
    frame_done = 1'b1;
    clear_req  = 1'b1;
    #1;
    check("same_ready", 32'(req_ready), 32'h4);
    step;
    frame_done = 1'b0;
    clear_req  = 1'b0;
    check("same_clearing", 32'(clearing), 32'h1);
    sweep_errs = 0;
    run_sweep(0, 19199, 100, 50);
    check("sweep2_errs", 32'(sweep_errs), 32'h0);
    check("sweep2_done", 32'(clearing), 32'h0);
    frame_done = 1'b1;
    #1;
    check("again_ready", 32'(req_ready), 32'h4);
    step;
    frame_done = 1'b0;
    check("again_clearing", 32'(clearing), 32'h1);
    sweep_errs = 0;
    run_sweep(0, 5000, -1, -1);
    check("sweep3_errs", 32'(sweep_errs), 32'h0);
    check("sweep3_addr", 32'(fb_addr), 32'd5000);

    // Reset mid-sweep drops everything immediately.
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(fb_we), 32'h0);
    check("mid_rst_clearing", 32'(clearing), 32'h0);
    check("mid_rst_addr", 32'(fb_addr), 32'h0);
    check("mid_rst_oob", 32'(oob_err), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    step;
    rst = 1'b0;
    req_valid = 3'b100;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h4);
    step;
    check("post_rst_we", 32'(fb_we), 32'h1);
    check("post_rst_addr", 32'(fb_addr), 32'd500);
    check("post_rst_data", 32'(fb_data), 32'h123456);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
